// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one video RAM port between a row fetcher and the CPU.
// Optional vid_underrun output when VRAM_UNDERRUN_DET_EN is defined.
// Ports: clk24/reset_n; vid_req/vid_row start a 128-byte row fetch into the
// line buffer (lb_we/lb_addr/lb_data, fetch_done); cpu_req/we/addr/wdata
// with cpu_ack/cpu_rdata; ram_addr/ram_rd/ram_wr/ram_d/ram_q to the RAM.
module vram_arbiter #(
  parameter int unsigned CPU_SLOT = 4
) (
  input  logic        clk24,
  input  logic        reset_n,
  input  logic        vid_req,
  input  logic [7:0]  vid_row,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q,
  output logic        lb_we,
  output logic [6:0]  lb_addr,
  output logic [7:0]  lb_data,
  output logic        fetch_done
`ifdef VRAM_UNDERRUN_DET_EN
  ,output logic       vid_underrun
`endif
);

  localparam logic [3:0] SLOT = 4'(CPU_SLOT);

  typedef enum logic [2:0] {
    IDLE, VRD, VCAP, CRD, CWR, CCAP
  } state_t;

  state_t      state, state_nxt;
  logic        fa, fa_nxt;
  logic [6:0]  idx, idx_nxt;
  logic [7:0]  row, row_nxt;
  logic [7:0]  row_pend;
  logic        pend;
  logic [3:0]  vcnt;
  logic        cap_rd;
  logic [15:0] addr_q;
  logic [7:0]  d_q;
  logic [7:0]  rdata_q;
  logic        apply;
  logic        last;
  logic        cpu_ok;
  logic        vid_go;
  logic        und_nxt;

  // A reload requested during VRD waits one cycle so the
  // in-flight byte lands at its own index.
  assign apply  = (state != VRD) && (vid_req || pend);
  assign last   = (state == VCAP) && (idx == 7'd127);
  assign cpu_ok = cpu_req && (state != CCAP);
  assign und_nxt = vid_req && fa && !last;

  always_comb begin
    fa_nxt  = fa;
    idx_nxt = idx;
    row_nxt = row;
    if (state == VCAP) begin
      idx_nxt = idx + 7'd1;
      if (last) fa_nxt = 1'b0;
    end
    if (apply) begin
      row_nxt = vid_req ? vid_row : row_pend;
      idx_nxt = 7'd0;
      fa_nxt  = 1'b1;
    end
  end

  assign vid_go = fa_nxt && (!cpu_ok || (vcnt < SLOT));

  always_comb begin
    state_nxt = IDLE;
    unique case (state)
      VRD:      state_nxt = VCAP;
      CRD, CWR: state_nxt = CCAP;
      default: begin
        if (vid_go)      state_nxt = VRD;
        else if (cpu_ok) state_nxt = cpu_we ? CWR : CRD;
        else             state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    ram_rd = (state == VRD) || (state == CRD);
    ram_wr = (state == CWR);
    if (state == VRD)
      ram_addr = {1'b1, idx[1:0], idx[6:2], row};
    else if ((state == CRD) || (state == CWR))
      ram_addr = cpu_addr;
    else
      ram_addr = addr_q;
    ram_d     = (state == CWR) ? cpu_wdata : d_q;
    lb_we     = (state == VCAP);
    lb_addr   = idx;
    lb_data   = lb_we ? ram_q : 8'h00;
    cpu_ack   = (state == CCAP);
    cpu_rdata = (cpu_ack && cap_rd) ? ram_q : rdata_q;
  end

  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fa         <= 1'b0;
      idx        <= 7'd0;
      row        <= 8'h00;
      row_pend   <= 8'h00;
      pend       <= 1'b0;
      vcnt       <= 4'd0;
      cap_rd     <= 1'b0;
      addr_q     <= 16'h0000;
      d_q        <= 8'h00;
      rdata_q    <= 8'h00;
      fetch_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      fa         <= fa_nxt;
      idx        <= idx_nxt;
      row        <= row_nxt;
      cap_rd     <= (state == CRD);
      addr_q     <= ram_addr;
      d_q        <= ram_d;
      rdata_q    <= cpu_rdata;
      fetch_done <= last;
      if ((state == VRD) && vid_req) begin
        pend     <= 1'b1;
        row_pend <= vid_row;
      end else if (apply) begin
        pend     <= 1'b0;
      end
      if (state_nxt == VRD) begin
        if (vcnt != 4'd15) vcnt <= vcnt + 4'd1;
      end else if ((state_nxt == CRD) || (state_nxt == CWR)) begin
        vcnt <= 4'd0;
      end
    end
  end

`ifdef VRAM_UNDERRUN_DET_EN
  always_ff @(posedge clk24 or negedge reset_n) begin
    if (!reset_n) vid_underrun <= 1'b0;
    else          vid_underrun <= und_nxt;
  end
`else
  logic und_unused;
  assign und_unused = und_nxt;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: CPU_SLOT, default 4, max consecutive video accesses while a CPU request waits (range 1..15).
REQ-002 Port: clk24  in  1  system clock, all logic on rising edge.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: vid_req  in  1  one-cycle pulse, start fetch of one framebuffer row.
REQ-005 Port: vid_row  in  8  row to fetch, sampled when vid_req=1.
REQ-006 Port: cpu_req  in  1  CPU access request, level, held until cpu_ack.
REQ-007 Port: cpu_we  in  1  1=write, 0=read; stable while cpu_req=1.
REQ-008 Port: cpu_addr  in  16  CPU byte address; stable while cpu_req=1.
REQ-009 Port: cpu_wdata  in  8  CPU write data; stable while cpu_req=1.
REQ-010 Port: cpu_rdata  out  8  CPU read data, valid while cpu_ack=1, held after.
REQ-011 Port: cpu_ack  out  1  one-cycle completion pulse.
REQ-012 Port: ram_addr  out  16  video RAM address.
REQ-013 Port: ram_rd  out  1  RAM read strobe; ram_q valid the following cycle.
REQ-014 Port: ram_wr  out  1  RAM write strobe.
REQ-015 Port: ram_d  out  8  RAM write data.
REQ-016 Port: ram_q  in  8  RAM read data.
REQ-017 Port: lb_we  out  1  line buffer write strobe.
REQ-018 Port: lb_addr  out  7  line buffer byte index.
REQ-019 Port: lb_data  out  8  line buffer write data.
REQ-020 Port: fetch_done  out  1  one-cycle pulse after the 128th line buffer write of a row.

Function
REQ-021 FSM states: IDLE, VRD, VCAP, CRD, CWR, CCAP; every access occupies exactly 2 cycles (issue, capture).
REQ-022 vid_req loads row register from vid_row, fetch index idx[6:0]=0, sets fetch_active.
REQ-023 VRD: ram_rd=1, ram_addr={1'b1, idx[1:0], idx[6:2], row[7:0]} (plane, column, row).
REQ-024 VCAP: lb_we=1, lb_addr=idx, lb_data=ram_q; idx increments by 1; at idx=127 fetch_active clears and fetch_done pulses in the same cycle.
REQ-025 CRD: ram_rd=1, ram_addr=cpu_addr; CCAP after CRD: cpu_rdata<=ram_q, cpu_ack=1.
REQ-026 CWR: ram_wr=1, ram_addr=cpu_addr, ram_d=cpu_wdata; CCAP after CWR: cpu_ack=1, cpu_rdata unchanged.
REQ-027 Decision made in IDLE, VCAP and CCAP for the next cycle: video if fetch_active and (cpu_req=0 or vcnt<CPU_SLOT); else CPU if cpu_req=1 and no ack in the current cycle; else IDLE.
REQ-028 vcnt (4 bits) increments per video grant, saturates at 15, clears on CPU grant.
REQ-029 cpu_req sampled in the cycle cpu_ack=1 is not a new request; earliest re-grant is the cycle after.
REQ-030 vid_req while fetch_active: the in-flight access completes, row reloads, idx=0, remaining old-row bytes are abandoned and fetch_done is not pulsed for the old row; a vid_req coinciding with VCAP idx=127 counts that row complete (fetch_done pulses).
REQ-031 With no requests pending, ram_rd, ram_wr, lb_we=0; ram_addr holds its last value.

Reset
REQ-032 reset_n=0 immediately forces IDLE; fetch_active, idx, vcnt, row, cpu_ack, ram_rd, ram_wr, lb_we, fetch_done=0; ram_addr, ram_d, lb_addr, lb_data, cpu_rdata=0.
REQ-033 An access in flight at reset is dropped, with no cpu_ack and no lb_we.

Configuration
REQ-034 Macro VRAM_UNDERRUN_DET_EN defined: extra output vid_underrun (1 bit, reset 0) pulses one cycle when vid_req arrives while fetch_active=1 (excluding the REQ-030 idx=127 coincidence).
REQ-035 Macro undefined: port vid_underrun absent; all other behaviour identical.

Verification
REQ-036 vid_req, vid_row=0x2A, no CPU -> 128 lb writes in 256 cycles, first ram_addr=0x802A, idx=4 address 0x812A, fetch_done 1 cycle after last lb_we.
REQ-037 cpu_req read, addr=0x1234, ram_q=0x5A, idle video -> ram_rd the cycle after request, cpu_ack and cpu_rdata=0x5A one cycle later.
REQ-038 Fetch active, cpu_req write held, CPU_SLOT=4 -> exactly 4 video accesses, then CWR, then video resumes; total fetch takes 258 cycles.
REQ-039 Second vid_req at idx=60 (macro on) -> vid_underrun pulse, no fetch_done for old row, new row fetched from idx=0.
REQ-040 reset_n low during CRD -> no cpu_ack, all outputs 0 asynchronously; after release a CPU read completes normally.
REQ-041 vid_req coincident with VCAP idx=127 -> fetch_done pulses, no vid_underrun, new fetch starts at idx=0.
